// File: rtl/muldiv_sched_if.sv
// rtl/muldiv_sched_if.sv - EX issue, mul/div unit and MEM result handshakes for muldiv_sched.
// master = scheduler view, slave = surrounding pipeline and execution units.
interface muldiv_sched_if;
   logic        ex_req_valid;
   logic        ex_req_ready;
   logic        ex_req_unit;
   logic        ex_req_sel;
   logic        mul_req_valid;
   logic        mul_req_ready;
   logic        div_req_valid;
   logic        div_req_ready;
   logic        mul_resp_valid;
   logic        mul_resp_ready;
   logic [63:0] mul_result;
   logic        div_resp_valid;
   logic        div_resp_ready;
   logic [31:0] div_quotient;
   logic [31:0] div_remainder;
   logic        mem_resp_valid;
   logic        mem_resp_ready;
   logic [31:0] mem_resp_data;

   modport master (
      input  ex_req_valid, ex_req_unit, ex_req_sel,
      output ex_req_ready,
      output mul_req_valid, div_req_valid,
      input  mul_req_ready, div_req_ready,
      input  mul_resp_valid, mul_result,
      output mul_resp_ready,
      input  div_resp_valid, div_quotient, div_remainder,
      output div_resp_ready,
      output mem_resp_valid, mem_resp_data,
      input  mem_resp_ready
   );

   modport slave (
      output ex_req_valid, ex_req_unit, ex_req_sel,
      input  ex_req_ready,
      input  mul_req_valid, div_req_valid,
      output mul_req_ready, div_req_ready,
      output mul_resp_valid, mul_result,
      input  mul_resp_ready,
      output div_resp_valid, div_quotient, div_remainder,
      input  div_resp_ready,
      input  mem_resp_valid, mem_resp_data,
      output mem_resp_ready
   );
endinterface

// File: rtl/muldiv_sched.sv
// rtl/muldiv_sched.sv - in-order mul/div issue/result scheduler with flush-drain tracking FIFO.
// Optional issue/stall counters enabled by MULDIV_SCHED_STAT_EN.
module muldiv_sched #(
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   muldiv_sched_if.master bus,
   output logic          busy,
   output logic [31:0]   stat_issue_cnt,
   output logic [31:0]   stat_stall_cnt
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
   localparam logic [PW:0]   CNT_ONE  = 1;
   localparam logic [PW-1:0] PTR_ONE  = 1;

   logic [PW:0]      count_q, count_d;
   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [DEPTH-1:0] unit_q, unit_d, sel_q, sel_d, alive_q, alive_d;

   logic full, empty, head_unit, head_sel, head_alive;
   logic head_rvalid, head_rready, push, pop;

   always_comb begin
      full       = (count_q == FULL_CNT);
      empty      = (count_q == '0);
      head_unit  = unit_q[head_q];
      head_sel   = sel_q[head_q];
      head_alive = alive_q[head_q];

      bus.mul_req_valid = bus.ex_req_valid & ~bus.ex_req_unit & ~full & ~flush;
      bus.div_req_valid = bus.ex_req_valid &  bus.ex_req_unit & ~full & ~flush;
      bus.ex_req_ready  = ~full & ~flush &
                          (bus.ex_req_unit ? bus.div_req_ready : bus.mul_req_ready);

      head_rvalid        = head_unit ? bus.div_resp_valid : bus.mul_resp_valid;
      head_rready        = 1'b0;
      bus.mem_resp_valid = 1'b0;
      if (!empty) begin
         // Killed entries (or anything during flush) are swallowed without reaching MEM.
         if (head_alive && !flush) begin
            bus.mem_resp_valid = head_rvalid;
            head_rready        = bus.mem_resp_ready;
         end else begin
            head_rready = 1'b1;
         end
      end
      bus.mul_resp_ready = head_rready & ~head_unit;
      bus.div_resp_ready = head_rready &  head_unit;

      case ({head_unit, head_sel})
         2'b00:   bus.mem_resp_data = bus.mul_result[31:0];
         2'b01:   bus.mem_resp_data = bus.mul_result[63:32];
         2'b10:   bus.mem_resp_data = bus.div_quotient;
         default: bus.mem_resp_data = bus.div_remainder;
      endcase

      push = bus.ex_req_valid & bus.ex_req_ready;
      pop  = ~empty & head_rvalid & head_rready;
      busy = ~empty;
   end

   always_comb begin
      unit_d  = unit_q;
      sel_d   = sel_q;
      alive_d = flush ? '0 : alive_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) begin
         unit_d[tail_q]  = bus.ex_req_unit;
         sel_d[tail_q]   = bus.ex_req_sel;
         alive_d[tail_q] = 1'b1;
         tail_d          = tail_q + PTR_ONE;
      end
      if (pop) begin
         head_d = head_q + PTR_ONE;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         unit_q  <= '0;
         sel_q   <= '0;
         alive_q <= '0;
      end else begin
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         unit_q  <= unit_d;
         sel_q   <= sel_d;
         alive_q <= alive_d;
      end
   end

`ifdef MULDIV_SCHED_STAT_EN
   logic [31:0] stat_issue_q, stat_issue_d, stat_stall_q, stat_stall_d;

   always_comb begin
      stat_issue_d = stat_issue_q + {31'd0, push};
      stat_stall_d = stat_stall_q + {31'd0, bus.ex_req_valid & ~bus.ex_req_ready};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_issue_q <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_issue_q <= stat_issue_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_issue_cnt = stat_issue_q;
   assign stat_stall_cnt = stat_stall_q;
`else
   assign stat_issue_cnt = 32'h0;
   assign stat_stall_cnt = 32'h0;
`endif
endmodule
